mesh_stream_loader: RTL and testbench



---
 rtl/mesh_stream_loader.sv | 104 ++++++++++
 tb/tb_mesh_stream_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_stream_loader.sv
// Serial-to-mesh front end: loads a keyed stream row-major into a ROWS x COLS
// register mesh, pads short frames with the maximum key, and holds the snapshot until acked.
module mesh_stream_loader #(
  parameter  int WIDTH = 8,
  parameter  int ROWS  = 4,
  parameter  int COLS  = 4,
  localparam int N     = ROWS * COLS,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic [N*WIDTH-1:0] mesh_data,
  output logic [ROWS-1:0]    row_dir,
  output logic               mesh_valid,
  input  logic               mesh_ack,
  output logic [CW-1:0]      count
);

  typedef enum logic [1:0] {FILL, PAD, FULL} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_next;
  logic [CW-1:0]    idx, idx_next, count_next;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cells [N];

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    count_next = count;
    we         = 1'b0;
    wdata      = in_data;
    case (state)
      FILL: begin
        if (in_valid) begin
          we         = 1'b1;
          idx_next   = idx + CW'(1);
          count_next = count + CW'(1);
          if (idx == LAST)  state_next = FULL;
          else if (in_last) state_next = PAD;
        end
      end
      PAD: begin
        we       = 1'b1;
        wdata    = '1;
        idx_next = idx + CW'(1);
        if (idx == LAST) state_next = FULL;
      end
      FULL: begin
        if (mesh_ack) begin
          state_next = FILL;
          idx_next   = '0;
          count_next = '0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
      idx   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      count <= count_next;
    end
  end

  // NOTE: the mesh is reset because its cleared contents are observable on mesh_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) cells[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < N; i++)
        if (idx == CW'(i)) cells[i] <= wdata;
    end
  end

  always_comb begin
    mesh_data = '0;
    for (int i = 0; i < N; i++) mesh_data[i*WIDTH +: WIDTH] = cells[i];
  end

  // Odd rows sort descending so the mesh reads as a snake.
  always_comb begin
    row_dir = '0;
    for (int r = 0; r < ROWS; r++) row_dir[r] = r[0];
  end

  assign in_ready   = (state == FILL);
  assign mesh_valid = (state == FULL);

endmodule

// File: tb/tb_mesh_stream_loader.sv
// Bench for mesh_stream_loader: a frame-level model checked every cycle on the 4x4 instance,
// plus directed literal checks on the 4x4 and a 1x1 instance.
module tb_mesh_stream_loader;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0, in_last = 1'b0, mesh_ack = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready, mesh_valid;
  logic [127:0] mesh_data;
  logic [3:0]   row_dir;
  logic [4:0]   count;

  logic         s_valid = 1'b0, s_last = 1'b0, s_ack = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         s_ready, s_mvalid;
  logic [7:0]   s_mesh;
  logic [0:0]   s_dir;
  logic [0:0]   s_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mesh_stream_loader #(.WIDTH(8), .ROWS(4), .COLS(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mesh_data(mesh_data), .row_dir(row_dir),
    .mesh_valid(mesh_valid), .mesh_ack(mesh_ack), .count(count)
  );

  mesh_stream_loader #(.WIDTH(8), .ROWS(1), .COLS(1)) dut_1x1 (
    .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .in_last(s_last), .mesh_data(s_mesh), .row_dir(s_dir),
    .mesh_valid(s_mvalid), .mesh_ack(s_ack), .count(s_count)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame model: cells written so far, real keys taken, and whether the tail is being padded.
  logic [7:0] m_cells [N];
  int         m_filled = 0;
  int         m_keys = 0;
  bit         m_pad = 1'b0;

  initial for (int i = 0; i < N; i++) m_cells[i] = 8'h00;

  function automatic logic [127:0] m_mesh();
    logic [127:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_cells[i];
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_cells[i] = 8'h00;
      m_filled = 0;
      m_keys   = 0;
      m_pad    = 1'b0;
    end else if (m_filled == N) begin
      if (mesh_ack) begin
        m_filled = 0;
        m_keys   = 0;
      end
    end else if (m_pad) begin
      m_cells[m_filled] = 8'hFF;
      m_filled++;
      if (m_filled == N) m_pad = 1'b0;
    end else if (in_valid) begin
      m_cells[m_filled] = in_data;
      m_filled++;
      m_keys++;
      if (in_last && m_filled < N) m_pad = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("model_mesh", mesh_data, m_mesh());
    check("model_count", count, m_keys);
    check("model_mesh_valid", mesh_valid, m_filled == N);
    check("model_in_ready", in_ready, (m_filled < N) && !m_pad);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] exp;
    int n;
    int sent;

    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    check("reset_in_ready", in_ready, 1);
    check("reset_mesh_valid", mesh_valid, 0);
    check("reset_count", count, 0);
    check("reset_mesh", mesh_data, 0);
    step();

    // Full frame 16..1, back to back, with in_last on the final key.
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(16 - i);
      in_last  = (i == N - 1);
      step();
    end
    in_last = 1'b0;
    in_data = 8'hAA;
    for (int i = 0; i < N; i++) exp[i*8 +: 8] = 8'(16 - i);
    check("full_mesh_valid", mesh_valid, 1);
    check("full_mesh", mesh_data, exp);
    check("full_cell00", mesh_data[7:0], 8'd16);
    check("full_cell33", mesh_data[127:120], 8'd1);
    check("full_count", count, 16);
    check("full_row_dir", row_dir, 4'b1010);
    check("full_in_ready", in_ready, 0);

    // in_valid held high while FULL must not capture anything.
    repeat (10) step();
    check("full_hold_mesh", mesh_data, exp);
    check("full_hold_count", count, 16);

    in_valid = 1'b0;
    mesh_ack = 1'b1;
    step();
    mesh_ack = 1'b0;
    check("ack_in_ready", in_ready, 1);
    check("ack_mesh_valid", mesh_valid, 0);

    // Short frame 7,2,9; first key lands the cycle after the ack, ack during FILL is ignored.
    in_valid = 1'b1;
    in_data  = 8'd7;
    mesh_ack = 1'b1;
    step();
    mesh_ack = 1'b0;
    check("first_cell_after_ack", mesh_data[7:0], 8'd7);
    in_data = 8'd2;
    step();
    in_data = 8'd9;
    in_last = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    n = 0;
    while (!mesh_valid && n < 40) begin
      mesh_ack = (n == 2);
      step();
      n++;
    end
    mesh_ack = 1'b0;
    check("pad_cycles", n, 13);
    exp = '1;
    exp[7:0]   = 8'd7;
    exp[15:8]  = 8'd2;
    exp[23:16] = 8'd9;
    check("short_mesh", mesh_data, exp);
    check("short_count", count, 3);
    mesh_ack = 1'b1;
    step();
    mesh_ack = 1'b0;

    // Random gaps on in_valid: cells must appear in arrival order.
    n = 0;
    sent = 0;
    while (sent < N && n < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      if (in_valid) begin
        exp[sent*8 +: 8] = in_data;
        sent++;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    check("bp_sent", sent, N);
    check("bp_mesh_valid", mesh_valid, 1);
    check("bp_mesh", mesh_data, exp);
    repeat (10) step();
    check("bp_delayed_ack_mesh", mesh_data, exp);
    mesh_ack = 1'b1;
    step();
    mesh_ack = 1'b0;

    // Asynchronous reset mid-FILL after five keys.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + i);
      step();
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_mesh", mesh_data, 0);
    check("async_rst_count", count, 0);
    check("async_rst_mesh_valid", mesh_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h42;
    step();
    in_valid = 1'b0;
    check("after_rst_cell00", mesh_data[7:0], 8'h42);
    check("after_rst_count", count, 1);

    // 1x1 mesh: a single key with in_last goes straight to FULL.
    check("n1_in_ready", s_ready, 1);
    s_valid = 1'b1;
    s_data  = 8'h3C;
    s_last  = 1'b1;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("n1_mesh_valid", s_mvalid, 1);
    check("n1_count", s_count, 1);
    check("n1_mesh", s_mesh, 8'h3C);
    check("n1_row_dir", s_dir, 1'b0);
    check("n1_in_ready_full", s_ready, 0);
    step();
    check("n1_no_pad", s_mvalid, 1);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    check("n1_ack_ready", s_ready, 1);
    check("n1_ack_valid", s_mvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
